// File: rtl/sseg_scan_capture.sv
// -----------------------------------------------------------------------------
// sseg_scan_capture
//
// Receive side of a 4-digit time-multiplexed seven-segment scan bus. The block
// watches the scanned anode/segment pair and demultiplexes it back into four
// static digit registers. It also pulses a frame strobe once all four digits
// have been captured.
//
// Every {an, sseg} pair passes through these steps:
//   1. It is synchronized through SYNC_STAGES flops.
//   2. It must then stay unchanged for STABLE_CYCLES cycles.
//   3. It is qualified once per dwell.
//   4. It is acted upon one cycle later. That extra registered stage gives a
//      latency of SYNC_STAGES + STABLE_CYCLES + 1 edges from the first sample
//      to the digit update.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   an_i[3:0]      scanned anode enables, active-low
//   sseg_i[6:0]    scanned segment pattern, captured raw
//   digit0_o..3_o  last captured pattern for anode 1110/1101/1011/0111
//   frame_valid_o  one-cycle pulse when all four digits have been captured
//   error_o        one-cycle pulse when a stable illegal anode pattern qualifies
// -----------------------------------------------------------------------------
module sseg_scan_capture #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] an_i,
  input  logic [6:0] sseg_i,
  output logic [6:0] digit0_o,
  output logic [6:0] digit1_o,
  output logic [6:0] digit2_o,
  output logic [6:0] digit3_o,
  output logic       frame_valid_o,
  output logic       error_o
);

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_QUAL = CW'(STABLE_CYCLES - 1);
  localparam logic [10:0]     IDLE_PAIR = {4'hF, 7'h00};

  // Synchronizer chain; each entry holds the {an, sseg} pair.
  logic [10:0]   sync_q [SYNC_STAGES];
  logic [10:0]   s;
  logic [10:0]   s_q;
  logic [CW-1:0] cnt_q;
  logic          captured_q;
  logic          changed;
  logic          qualify;

  // Registered qualification: the pair plus a valid flag.
  logic          qual_q;
  logic [10:0]   qual_pair_q;

  // Decode of the qualified anode half.
  logic [3:0]    hit;
  logic          illegal;

  logic [6:0]    digit_q [4];
  logic [3:0]    seen_q;

  assign s       = sync_q[SYNC_STAGES-1];
  assign changed = (s != s_q);
  assign qualify = !changed && (cnt_q == CNT_QUAL) && !captured_q;

  // NOTE: sequential state uses non-blocking assignments only. Then every flop
  // in the chain samples the pre-edge value, regardless of statement order.
  //
  // NOTE: the synchronizer and digit arrays are reset explicitly. They are
  // small flop arrays, not RAM, and their reset values are architecturally
  // visible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_PAIR;
      s_q <= IDLE_PAIR;
    end else begin
      sync_q[0] <= {an_i, sseg_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_q <= s;
    end
  end

  // Stability counter. The captured flag limits each dwell to a single
  // qualification, however long the dwell lasts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      captured_q  <= 1'b0;
      qual_q      <= 1'b0;
      qual_pair_q <= IDLE_PAIR;
    end else begin
      qual_q <= qualify;
      if (qualify) qual_pair_q <= s_q;
      if (changed) begin
        cnt_q      <= '0;
        captured_q <= 1'b0;
      end else begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        if (qualify) captured_q <= 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default before the case. This
  // keeps an unlisted anode value from inferring a latch.
  always_comb begin
    hit     = 4'b0000;
    illegal = 1'b0;
    unique case (qual_pair_q[10:7])
      4'b1110: hit = 4'b0001;
      4'b1101: hit = 4'b0010;
      4'b1011: hit = 4'b0100;
      4'b0111: hit = 4'b1000;
      4'b1111: ;               // blanking: nothing to capture
      default: illegal = 1'b1;
    endcase
  end

  // Capture, frame tracking and the pulse outputs. The strobe fires in the
  // same cycle as the digit write that completes the mask.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) digit_q[i] <= 7'h00;
      seen_q        <= 4'b0000;
      frame_valid_o <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      frame_valid_o <= 1'b0;
      error_o       <= 1'b0;
      if (qual_q) begin
        if (illegal) begin
          error_o <= 1'b1;
        end else if (hit != 4'b0000) begin
          for (int i = 0; i < 4; i++)
            if (hit[i]) digit_q[i] <= qual_pair_q[6:0];
          if ((seen_q | hit) == 4'b1111) begin
            frame_valid_o <= 1'b1;
            seen_q        <= 4'b0000;
          end else begin
            seen_q <= seen_q | hit;
          end
        end
      end
    end
  end

  assign digit0_o = digit_q[0];
  assign digit1_o = digit_q[1];
  assign digit2_o = digit_q[2];
  assign digit3_o = digit_q[3];

endmodule

// File: tb/tb_sseg_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_capture
//
// Scoreboard bench for sseg_scan_capture.
// - Each scenario task pushes the digit changes, frame strobes and error
//   pulses that it expects.
// - A monitor records every observable event, with its cycle stamp.
// - The task then pops both queues and compares them inline.
// -----------------------------------------------------------------------------
module tb_sseg_scan_capture;

  localparam logic [1:0] EV_NONE = 2'd0;
  localparam logic [1:0] EV_DIG  = 2'd1;
  localparam logic [1:0] EV_FRM  = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] idx;
    logic [6:0] val;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] an  = 4'hF;
  logic [6:0] sseg = 7'h00;
  logic [6:0] digit0, digit1, digit2, digit3;
  logic       frame_valid, error;

  logic [6:0] dig  [4];
  logic [6:0] prev [4];

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  evt_t exp_q [$];
  evt_t obs_q [$];
  int   obs_cyc [$];

  sseg_scan_capture #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .an_i(an), .sseg_i(sseg),
    .digit0_o(digit0), .digit1_o(digit1), .digit2_o(digit2), .digit3_o(digit3),
    .frame_valid_o(frame_valid), .error_o(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dig[0] = digit0;
  assign dig[1] = digit1;
  assign dig[2] = digit2;
  assign dig[3] = digit3;

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (dig[i] !== prev[i]) begin
        obs_q.push_back('{kind: EV_DIG, idx: 2'(i), val: dig[i]});
        obs_cyc.push_back(cyc);
        prev[i] = dig[i];
      end
    end
    if (frame_valid === 1'b1) begin
      obs_q.push_back('{kind: EV_FRM, idx: 2'd0, val: 7'h00});
      obs_cyc.push_back(cyc);
    end
    if (error === 1'b1) begin
      obs_q.push_back('{kind: EV_ERR, idx: 2'd0, val: 7'h00});
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Stimulus tasks all start and end 2 time units after a rising edge.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an   = a;
    sseg = s;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic pop_obs(output evt_t o, output int c);
    if (obs_q.size() == 0) begin
      o = '{kind: EV_NONE, idx: 2'd0, val: 7'h00};
      c = -1;
    end else begin
      o = obs_q.pop_front();
      c = obs_cyc.pop_front();
    end
  endtask

  task automatic push_exp(input logic [1:0] k, input logic [1:0] i, input logic [6:0] v);
    exp_q.push_back('{kind: k, idx: i, val: v});
  endtask

  task automatic test_reset();
    an   = 4'hF;
    sseg = 7'h00;
    repeat (3) @(posedge clk);
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dig[i] !== 7'h00) begin
        n_mis++;
        $display("FAIL reset_digit%0d: got %h, want 00", i, dig[i]);
      end
    end
    n_cmp++;
    if (frame_valid !== 1'b0 || error !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_pulses: got frame=%b error=%b, want 0/0", frame_valid, error);
    end
  endtask

  task automatic test_latency();
    evt_t e, o;
    int   c, edge0;
    do_reset();
    edge0 = cyc + 1;
    push_exp(EV_DIG, 2'd0, 7'h3F);
    an   = 4'b1110;
    sseg = 7'h3F;
    repeat (7) @(posedge clk);
    #2;
    n_cmp++;
    if (digit0 !== 7'h00) begin
      n_mis++;
      $display("FAIL latency_edge6: got digit0=%h, want 00", digit0);
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (digit0 !== 7'h3F) begin
      n_mis++;
      $display("FAIL latency_edge7: got digit0=%h, want 3f", digit0);
    end
    drive(4'b1110, 7'h3F, 2);
    drive(4'hF, 7'h00, 10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_obs(o, c);
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL latency_event: got k=%0d i=%0d v=%h, want k=%0d i=%0d v=%h",
                 o.kind, o.idx, o.val, e.kind, e.idx, e.val);
      end else begin
        n_cmp++;
        if (c != edge0 + 7) begin
          n_mis++;
          $display("FAIL latency_cycle: got update at edge %0d, want edge 7", c - edge0);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_mis++;
      $display("FAIL latency_extra: got %0d unexpected events, want 0", obs_q.size());
    end
  endtask

  task automatic test_scan();
    evt_t e, o;
    int   c;
    int   d3_cyc;
    do_reset();
    d3_cyc = -2;
    // digit0 captures 00 over a reset value of 00, so it produces no visible change.
    push_exp(EV_DIG, 2'd1, 7'h70);
    push_exp(EV_DIG, 2'd2, 7'h0F);
    push_exp(EV_DIG, 2'd3, 7'h7F);
    push_exp(EV_FRM, 2'd0, 7'h00);
    push_exp(EV_FRM, 2'd0, 7'h00);
    for (int pass = 0; pass < 2; pass++) begin
      drive(4'b1110, 7'h00, 20);
      drive(4'b1101, 7'h70, 20);
      drive(4'b1011, 7'h0F, 20);
      drive(4'b0111, 7'h7F, 20);
    end
    drive(4'hF, 7'h00, 10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_obs(o, c);
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL scan_event: got k=%0d i=%0d v=%h, want k=%0d i=%0d v=%h",
                 o.kind, o.idx, o.val, e.kind, e.idx, e.val);
      end
      if (o.kind == EV_DIG && o.idx == 2'd3) d3_cyc = c;
      if (o.kind == EV_FRM && d3_cyc != -2) begin
        n_cmp++;
        if (c != d3_cyc) begin
          n_mis++;
          $display("FAIL scan_frame_align: got frame at cycle %0d, want %0d", c, d3_cyc);
        end
        d3_cyc = -2;
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_mis++;
      $display("FAIL scan_extra: got %0d unexpected events, want 0", obs_q.size());
    end
  endtask

  task automatic test_glitch();
    evt_t e, o;
    int   c;
    do_reset();
    push_exp(EV_DIG, 2'd3, 7'h7F);
    drive(4'b0111, 7'h7F, 10);
    drive(4'b0111, 7'h01, 2);
    drive(4'b0111, 7'h7F, 20);
    drive(4'hF, 7'h00, 10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_obs(o, c);
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL glitch_event: got k=%0d i=%0d v=%h, want k=%0d i=%0d v=%h",
                 o.kind, o.idx, o.val, e.kind, e.idx, e.val);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_mis++;
      $display("FAIL glitch_extra: got %0d unexpected events, want 0", obs_q.size());
    end
    n_cmp++;
    if (digit3 !== 7'h7F) begin
      n_mis++;
      $display("FAIL glitch_final: got digit3=%h, want 7f", digit3);
    end
  endtask

  task automatic test_illegal();
    evt_t e, o;
    int   c;
    do_reset();
    push_exp(EV_ERR, 2'd0, 7'h00);
    drive(4'b1111, 7'h55, 50);
    drive(4'b1100, 7'h2A, 20);
    drive(4'hF, 7'h00, 10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_obs(o, c);
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL illegal_event: got k=%0d i=%0d v=%h, want k=%0d i=%0d v=%h",
                 o.kind, o.idx, o.val, e.kind, e.idx, e.val);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_mis++;
      $display("FAIL illegal_extra: got %0d unexpected events, want 0", obs_q.size());
    end
  endtask

  task automatic test_mid_reset();
    evt_t e, o;
    int   c;
    do_reset();
    push_exp(EV_DIG, 2'd0, 7'h11);
    push_exp(EV_DIG, 2'd1, 7'h22);
    push_exp(EV_DIG, 2'd2, 7'h33);
    drive(4'b1110, 7'h11, 20);
    drive(4'b1101, 7'h22, 20);
    drive(4'b1011, 7'h33, 20);
    drive(4'hF, 7'h00, 10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_obs(o, c);
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL midrst_pre_event: got k=%0d i=%0d v=%h, want k=%0d i=%0d v=%h",
                 o.kind, o.idx, o.val, e.kind, e.idx, e.val);
      end
    end
    do_reset();
    push_exp(EV_DIG, 2'd3, 7'h44);
    drive(4'b0111, 7'h44, 20);
    drive(4'hF, 7'h00, 10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_obs(o, c);
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL midrst_post_event: got k=%0d i=%0d v=%h, want k=%0d i=%0d v=%h",
                 o.kind, o.idx, o.val, e.kind, e.idx, e.val);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_mis++;
      $display("FAIL midrst_extra: got %0d unexpected events, want 0", obs_q.size());
    end
    n_cmp++;
    if (digit0 !== 7'h00 || digit1 !== 7'h00 || digit2 !== 7'h00 || digit3 !== 7'h44) begin
      n_mis++;
      $display("FAIL midrst_digits: got %h %h %h %h, want 00 00 00 44",
               digit0, digit1, digit2, digit3);
    end
  endtask

  task automatic test_long_dwell();
    evt_t e, o;
    int   c;
    do_reset();
    push_exp(EV_DIG, 2'd1, 7'h5A);
    drive(4'b1101, 7'h5A, 1000);
    drive(4'hF, 7'h00, 10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_obs(o, c);
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL long_event: got k=%0d i=%0d v=%h, want k=%0d i=%0d v=%h",
                 o.kind, o.idx, o.val, e.kind, e.idx, e.val);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_mis++;
      $display("FAIL long_extra: got %0d unexpected events, want 0", obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_scan();
    test_glitch();
    test_illegal();
    test_mid_reset();
    test_long_dwell();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
